// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the multi-cycle signed divider.
//   - div_state_e   : controller states (IDLE, RUN, DONE)
//   - DIV_DEFAULT_W : default operand/result width
//   - DIV_CNT_W     : iteration-counter width for the default width
//   - div_cnt_w()   : iteration-counter width for an arbitrary width
package div_pkg;

  localparam int DIV_DEFAULT_W = 32;
  localparam int DIV_CNT_W     = $clog2(DIV_DEFAULT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // The counter runs 0..width-1, so clog2(width) bits suffice; widths below
  // two are not supported but still get a one-bit counter.
  function automatic int div_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_unit_negate_cond.sv
// negate_cond: WIDTH-bit conditional two's complement.
//   i_neg : when high, o_val = ~i_val + 1 (modulo 2^WIDTH); else o_val = i_val
//   i_val : input value
//   o_val : conditionally negated value
module negate_cond #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  logic [WIDTH-1:0] w_one;

  assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};
  assign o_val = i_neg ? (~i_val + w_one) : i_val;

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed integer divider (restoring shift-subtract,
// one quotient bit per clock).
//
// Ports:
//   clock          : rising-edge clock
//   reset_n        : asynchronous active-low reset
//   ctrl_DIV       : start pulse, sampled only while idle
//   data_operandA  : dividend (two's complement)
//   data_operandB  : divisor (two's complement)
//   data_result    : signed quotient, held until the next completion
//   data_remainder : signed remainder (only when DIV_REMAINDER_EN is defined)
//   data_exception : divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY : one-cycle completion strobe
//   busy           : high while the shift-subtract loop is running
//
// Build option: define DIV_REMAINDER_EN to expose data_remainder and its
// sign-fix logic. Without it the remainder is kept internally only.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_babs;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_sign;
  logic             r_div0;

  logic [WIDTH-1:0] w_aabs;
  logic [WIDTH-1:0] w_babs;
  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_quo_fix;
  logic             w_b_zero;

  assign w_b_zero = (data_operandB == '0);

  // Magnitudes of the operands. The most negative value maps onto itself,
  // which read as unsigned is the correct magnitude 2^(WIDTH-1).
  negate_cond #(.WIDTH(WIDTH)) u_abs_a (
    .i_neg (data_operandA[WIDTH-1]),
    .i_val (data_operandA),
    .o_val (w_aabs)
  );

  negate_cond #(.WIDTH(WIDTH)) u_abs_b (
    .i_neg (data_operandB[WIDTH-1]),
    .i_val (data_operandB),
    .o_val (w_babs)
  );

  negate_cond #(.WIDTH(WIDTH)) u_fix_q (
    .i_neg (r_q_sign),
    .i_val (r_quo),
    .o_val (w_quo_fix)
  );

`ifdef DIV_REMAINDER_EN
  logic             r_r_sign;
  logic [WIDTH-1:0] w_rem_fix;

  // Remainder follows the sign of the dividend so that q*B + r == A.
  negate_cond #(.WIDTH(WIDTH)) u_fix_r (
    .i_neg (r_r_sign),
    .i_val (r_rem),
    .o_val (w_rem_fix)
  );
`endif

  // {rem, quo} shifted left by one: the dividend bits stream out of the top
  // of r_quo into the partial remainder while quotient bits fill from below.
  // The partial remainder is always below |B| <= 2^(WIDTH-1), so the shift
  // never loses a bit; the trial subtraction needs one extra bit for the sign.
  assign w_rem_sh = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_trial  = {1'b0, w_rem_sh} - {1'b0, r_babs};

  assign busy = (r_state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_babs         <= '0;
      r_quo          <= '0;
      r_rem          <= '0;
      r_cnt          <= '0;
      r_q_sign       <= 1'b0;
      r_div0         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_r_sign       <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ctrl_DIV) begin
            r_babs   <= w_babs;
            r_quo    <= w_aabs;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_q_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_div0   <= w_b_zero;
`ifdef DIV_REMAINDER_EN
            r_r_sign <= data_operandA[WIDTH-1];
`endif
            // A zero divisor skips the loop entirely.
            r_state  <= w_b_zero ? ST_DONE : ST_RUN;
          end
        end

        ST_RUN: begin
          // Restore (keep the shifted remainder) when the trial goes negative.
          r_rem   <= w_trial[WIDTH] ? w_rem_sh : w_trial[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          data_result    <= r_div0 ? '0 : w_quo_fix;
          data_exception <= r_div0;
          data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
          data_remainder <= r_div0 ? '0 : w_rem_fix;
`endif
          r_state        <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit with a queue-based
// scoreboard of expected quotient/remainder/exception/latency/busy length.
module tb_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
`ifdef DIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  div_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt++;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           lat;
    int           bsy;
    int           start_edge;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   busy_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a start pulse, wait for the accepting edge, and push the
  // expected outcome onto the scoreboard.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ee);
    exp_t x;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV     = 1'b0;
    x.q          = eq;
    x.r          = er;
    x.e          = ee;
    x.lat        = ee ? 1 : W + 1;
    x.bsy        = ee ? 0 : W;
    x.start_edge = edge_cnt;
    sb.push_back(x);
    busy_seen = busy ? 1 : 0;
  endtask

  // Wait (bounded) for the strobe, then pop and compare. pulse_at >= 0 fires
  // a spurious 9/3 start request that many cycles into the wait.
  task automatic wait_result(input string tag, input int pulse_at);
    exp_t x;
    bit   got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k == pulse_at) begin
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
      end
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_seen++;
    end
    check({tag, "_strobe"}, 64'(got), 64'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({tag, "_q"}, data_result, x.q);
      check({tag, "_exc"}, data_exception, x.e);
      check({tag, "_lat"}, edge_cnt - x.start_edge, x.lat);
      check({tag, "_busy"}, busy_seen, x.bsy);
`ifdef DIV_REMAINDER_EN
      check({tag, "_r"}, data_remainder, x.r);
`endif
    end
  endtask

  int rdy_cnt;

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_q", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
`ifdef DIV_REMAINDER_EN
    check("rst_r", data_remainder, 0);
`endif
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic signed cases
    start_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_result("p100_p7", -1);
    @(posedge clock);
    #1;
    check("p100_p7_rdy_low", data_resultRDY, 0);
    check("p100_p7_hold", data_result, 32'd14);

    start_div(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    wait_result("n100_p7", -1);
    start_div(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
    wait_result("p100_n7", -1);
    start_div(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0);
    wait_result("n7_n2", -1);

    // Divide by zero
    start_div(32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_result("div0", -1);

    // Boundaries
    start_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    wait_result("min_n1", -1);
    start_div(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0);
    wait_result("max_min", -1);
    start_div(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    wait_result("min_min", -1);

    // Start while busy is ignored; back-to-back start in the strobe cycle
    start_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    wait_result("ignore", 4);
    start_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_result("b2b", -1);

    // Asynchronous reset in the middle of a run
    start_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    repeat (9) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_q", data_result, 0);
    check("mid_rst_exc", data_exception, 0);
    check("mid_rst_rdy", data_resultRDY, 0);
    check("mid_rst_busy", busy, 0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_cnt++;
    end
    check("mid_rst_no_strobe", rdy_cnt, 0);
    start_div(32'd8, 32'd2, 32'd4, 32'd0, 1'b0);
    wait_result("after_rst", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
